imem_loader: RTL

Boot-time controller that fills the instruction ROM from a byte stream and holds the core in reset until a complete, checksum-verified image is in place. It sits between a byte source (UART receiver or debug bridge) and the instruction memory's write port. Its `core_hold` output is ORed into the pipeline reset, so fetch sees only a finished image.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_word_packer.sv | 35 +++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding, stream framing constants and the header range check.
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam int ROM_SIZE_DEFAULT = 128;
    localparam int HDR_BYTES        = 2;
    localparam int WORD_BYTES       = 4;

    // A header is usable only if it names between one word and the whole ROM.
    function automatic logic hdr_ok(input logic [15:0] n, input int unsigned rom_size);
        return (n != 16'd0) && ({16'd0, n} <= rom_size);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects four stream bytes into one little-endian 32-bit word and flags
// the cycle in which the fourth byte arrives.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_r;
    logic [31:0] shift_r;

    // Bytes enter at the top and shift down, so byte k ends in bits [8k+7:8k].
    assign word       = {byte_data, shift_r[31:8]};
    assign word_valid = byte_valid && (cnt_r == LAST_BYTE_IDX);

    // Byte counter and assembly register, restarted at the beginning of each load.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (byte_valid) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {byte_data, shift_r[31:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills the instruction memory from a framed byte stream and
// keeps the core held in reset until a checksum-verified image is present.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ROM_SIZE = ROM_SIZE_DEFAULT,
    parameter int ADDR_W   = $clog2(ROM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_next_s;
    logic              rx_ready_s;
    logic              clear_s;
    logic              accept_s;
    logic              data_byte_s;
    logic              word_valid_s;
    logic [31:0]       word_s;
    logic [15:0]       hdr_n_s;
    logic              last_word_s;

    logic              hdr_cnt_r;
    logic [7:0]        hdr_lo_r;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [7:0]        csum_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              core_hold_r;
    logic              done_r;
    logic              error_r;

    assign accept_s    = rx_valid && rx_ready_s;
    assign data_byte_s = rx_valid && (state_r == ST_DATA);
    assign hdr_n_s     = {rx_data, hdr_lo_r};
    assign last_word_s = ((word_idx_r + ONE_W) == n_r);

    assign rx_ready  = rx_ready_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign core_hold = core_hold_r;
    assign done      = done_r;
    assign error     = error_r;

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .byte_valid (data_byte_s),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state decode; start only takes effect from a resting state.
    always_comb begin
        state_next_s = state_r;
        rx_ready_s   = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_HDR;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HDR: begin
                rx_ready_s = 1'b1;
                if (rx_valid && hdr_cnt_r) begin
                    if (hdr_ok(hdr_n_s, ROM_SIZE)) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_DATA: begin
                rx_ready_s = 1'b1;
                if (word_valid_s && last_word_s) begin
                    state_next_s = ST_CSUM;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                rx_ready_s = 1'b1;
                if (rx_valid) begin
                    if (rx_data == csum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with the status levels registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            core_hold_r <= (state_next_s != ST_DONE);
            done_r      <= (state_next_s == ST_DONE);
            error_r     <= (state_next_s == ST_ERR);
        end
    end

    // Header capture, running checksum, word counter and memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt_r   <= 1'b0;
            hdr_lo_r    <= 8'd0;
            n_r         <= '0;
            word_idx_r  <= '0;
            csum_r      <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= word_valid_s;
            if (clear_s) begin
                hdr_cnt_r  <= 1'b0;
                n_r        <= '0;
                word_idx_r <= '0;
                csum_r     <= 8'd0;
            end else begin
                if (accept_s && (state_r != ST_CSUM)) begin
                    csum_r <= csum_r ^ rx_data;
                end
                if (accept_s && (state_r == ST_HDR)) begin
                    hdr_cnt_r <= 1'b1;
                    if (hdr_cnt_r) begin
                        n_r <= hdr_n_s[ADDR_W:0];
                    end else begin
                        hdr_lo_r <= rx_data;
                    end
                end
                if (word_valid_s) begin
                    mem_addr_r  <= word_idx_r[ADDR_W-1:0];
                    mem_wdata_r <= word_s;
                    word_idx_r  <= word_idx_r + ONE_W;
                end
            end
        end
    end

endmodule
